// File: rtl/pr_bridge_pkg.sv
// Shared types and constants for the processor-to-IO bridge.
// Holds the access FSM encoding, the error read value and address field positions.
package pr_bridge_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_e;

  localparam logic [31:0] ERR_DATA = 32'hFFFF_FFFF;

  // Bit positions within the byte address PrAddr[31:2]
  localparam int PAGE_MSB = 31;
  localparam int PAGE_LSB = 12;
  localparam int IDX_MSB  = 10;
  localparam int IDX_LSB  = 8;
  localparam int ADDR_MSB = 7;
  localparam int ADDR_LSB = 2;

endpackage

// File: rtl/pr_sync2.sv
// Two-flop synchronizer for one asynchronous level signal.
module pr_sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic ff1_q, ff1_d;
  logic ff2_q, ff2_d;

  always_comb begin
    ff1_d = d;
    ff2_d = ff1_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ff1_q <= 1'b0;
      ff2_q <= 1'b0;
    end else begin
      ff1_q <= ff1_d;
      ff2_q <= ff2_d;
    end
  end

  assign q = ff2_q;

endmodule

// File: rtl/pr_bridge.sv
// Bridge from the CPU MEM stage to up to six IO devices in one 4 KB page.
// Mapped accesses stall the pipeline until the device is ready or the access times out.
module pr_bridge
  import pr_bridge_pkg::*;
#(
  parameter int          NDEV    = 4,
  parameter logic [19:0] IO_PAGE = 20'h0007F,
  parameter int          TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:2]      PrAddr,
  input  logic [31:0]      PrWD,
  input  logic [3:0]       PrBE,
  input  logic             IOWrite,
  input  logic             IORead,
  output logic [31:0]      PrRD,
  output logic             pr_stall,
  output logic             bus_err,
  output logic [NDEV-1:0]  dev_sel,
  output logic             dev_we,
  output logic [5:0]       dev_addr,
  output logic [31:0]      dev_wd,
  output logic [3:0]       dev_be,
  input  logic [NDEV*32-1:0] dev_rd,
  input  logic [NDEV-1:0]  dev_ready,
  input  logic [NDEV-1:0]  dev_irq,
  output logic [7:2]       HWInt
);

  localparam logic [3:0] NDEV_L   = 4'(NDEV);
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic        we_q, we_d;
  logic [2:0]  idx_q, idx_d;
  logic [5:0]  addr_q, addr_d;
  logic [31:0] wd_q, wd_d;
  logic [3:0]  be_q, be_d;

  logic            req, mapped;
  logic [2:0]      req_idx;
  logic [31:0]     sel_rd;
  logic            sel_ready;
  logic [NDEV-1:0] sel_onehot;
  logic            unused_addr;

  assign req         = IOWrite | IORead;
  assign req_idx     = PrAddr[IDX_MSB:IDX_LSB];
  assign mapped      = (PrAddr[PAGE_MSB:PAGE_LSB] == IO_PAGE) && ({1'b0, req_idx} < NDEV_L);
  assign unused_addr = PrAddr[11];

  // Only the latched device index is ever looked at, so stray ready/data are ignored.
  always_comb begin
    sel_rd     = '0;
    sel_ready  = 1'b0;
    sel_onehot = '0;
    for (int i = 0; i < NDEV; i++) begin
      if (idx_q == 3'(i)) begin
        sel_rd        = dev_rd[i*32 +: 32];
        sel_ready     = dev_ready[i];
        sel_onehot[i] = 1'b1;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    we_d     = we_q;
    idx_d    = idx_q;
    addr_d   = addr_q;
    wd_d     = wd_q;
    be_d     = be_q;
    pr_stall = 1'b0;
    PrRD     = '0;
    bus_err  = 1'b0;
    dev_sel  = '0;
    dev_we   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (req && mapped) begin
          pr_stall = 1'b1;
          idx_d    = req_idx;
          addr_d   = PrAddr[ADDR_MSB:ADDR_LSB];
          wd_d     = PrWD;
          be_d     = PrBE;
          we_d     = IOWrite;
          cnt_d    = '0;
          err_d    = 1'b0;
          rdata_d  = '0;
          state_d  = ST_ACCESS;
        end else if (req) begin
          bus_err = 1'b1;
        end
      end
      ST_ACCESS: begin
        pr_stall = 1'b1;
        dev_sel  = sel_onehot;
        dev_we   = we_q;
        if (sel_ready) begin
          rdata_d = we_q ? 32'h0 : sel_rd;
          err_d   = 1'b0;
          state_d = ST_DONE;
        end else if (cnt_q == CNT_LAST) begin
          rdata_d = ERR_DATA;
          err_d   = 1'b1;
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      ST_DONE: begin
        PrRD    = rdata_q;
        bus_err = err_q;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      we_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      we_q    <= we_d;
    end
  end

  // Request payload is only consumed in ACCESS, after it has been loaded.
  always_ff @(posedge clk) begin
    idx_q  <= idx_d;
    addr_q <= addr_d;
    wd_q   <= wd_d;
    be_q   <= be_d;
  end

  assign dev_addr = addr_q;
  assign dev_wd   = wd_q;
  assign dev_be   = be_q;

  for (genvar i = 0; i < 6; i++) begin : g_irq
    if (i < NDEV) begin : g_sync
      pr_sync2 u_sync (
        .clk (clk),
        .rst (rst),
        .d   (dev_irq[i]),
        .q   (HWInt[2+i])
      );
    end else begin : g_tie
      assign HWInt[2+i] = 1'b0;
    end
  end

endmodule
